// File: rtl/irq_arb_pkg.sv
// irq_arb_pkg: shared types, defaults and the lowest-set-bit helper for
// irq_priority_arbiter (round-robin option: IRQ_ARB_ROUND_ROBIN_EN).
package irq_arb_pkg;

    localparam int DEF_NUM_CH  = 9;
    localparam int DEF_NUM_LVL = 3;
    localparam int MAX_CH      = 32;
    localparam int MAX_ID_W    = 5;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    function automatic pick_t first_set(input logic [MAX_CH-1:0] vec);
        pick_t r;
        r = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = MAX_ID_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_arb_pick.sv
// irq_arb_pick: combinational picker for one priority level; searches from
// the pointer upward first, then wraps to the lowest set channel.
module irq_arb_pick
    import irq_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] cand,
    input  logic [ID_W-1:0]   ptr,
    output logic              found,
    output logic [ID_W-1:0]   idx
);

    logic [MAX_CH-1:0] wide;
    logic [MAX_CH-1:0] upper;
    pick_t             hi;
    pick_t             lo;
    pick_t             sel;

    always_comb begin
        wide  = '0;
        upper = '0;
        wide[NUM_CH-1:0] = cand;
        for (int c = 0; c < NUM_CH; c++) begin
            upper[c] = cand[c] && (c >= int'(ptr));
        end
        hi    = first_set(upper);
        lo    = first_set(wide);
        sel   = hi.found ? hi : lo;
        found = sel.found;
        idx   = sel.idx[ID_W-1:0];
    end

endmodule

// File: rtl/irq_priority_arbiter.sv
// irq_priority_arbiter: edge-captured pending bits, multi-level priority
// resolution, registered valid/ready grant. Option: IRQ_ARB_ROUND_ROBIN_EN.
module irq_priority_arbiter
    import irq_arb_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int NUM_LVL = DEF_NUM_LVL,
    parameter int ID_W    = $clog2(NUM_CH),
    parameter int LVL_W   = (NUM_LVL > 1) ? $clog2(NUM_LVL) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [NUM_LVL*NUM_CH-1:0] lvl_en_i,
    output logic                      grant_valid_o,
    input  logic                      grant_ready_i,
    output logic [ID_W-1:0]           grant_id_o,
    output logic [LVL_W-1:0]          grant_lvl_o,
    output logic [NUM_LVL-1:0]        lvl_any_o,
    output logic [NUM_CH-1:0]         pend_o
);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   req_q;
    logic [NUM_CH-1:0]   pend;
    logic [NUM_CH-1:0]   set;
    logic [NUM_CH-1:0]   clr;
    logic [NUM_CH-1:0]   pend_next;
    logic [NUM_CH-1:0]   src;
    logic                hs;
    logic [NUM_LVL-1:0]  lvl_hit;
    logic [NUM_LVL-1:0]  lvl_any_nxt;
    logic [ID_W-1:0]     lvl_idx [NUM_LVL];
    logic [ID_W-1:0]     ptr_eff [NUM_LVL];
    logic                any_cand;
    logic                load;
    logic [ID_W-1:0]     win_id;
    logic [LVL_W-1:0]    win_lvl;

    assign grant_valid_o = (state == STATE_HOLD);
    assign pend_o        = pend;
    assign hs            = grant_valid_o & grant_ready_i;
    assign set           = req_i & ~req_q;

    always_comb begin
        clr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            clr[c] = hs && (grant_id_o == ID_W'(c));
        end
    end

    assign pend_next = (pend & ~clr) | set;

    // A handshake reloads from pend_next so grants issue back to back.
    assign src = hs ? pend_next : pend;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr [NUM_LVL];
    logic [ID_W-1:0] ptr_adv;

    assign ptr_adv = (grant_id_o == ID_W'(NUM_CH - 1)) ?
                     '0 : grant_id_o + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < NUM_LVL; l++) begin
                ptr[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LVL; l++) begin
                if (hs && (grant_lvl_o == LVL_W'(l))) begin
                    ptr[l] <= ptr_adv;
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LVL; l++) begin
            ptr_eff[l] = ptr[l];
            if (hs && (grant_lvl_o == LVL_W'(l))) begin
                ptr_eff[l] = ptr_adv;
            end
        end
    end
`else
    always_comb begin
        for (int l = 0; l < NUM_LVL; l++) begin
            ptr_eff[l] = '0;
        end
    end
`endif

    for (genvar l = 0; l < NUM_LVL; l++) begin : g_lvl
        irq_arb_pick #(
            .NUM_CH (NUM_CH),
            .ID_W   (ID_W)
        ) u_pick (
            .cand  (src & lvl_en_i[l*NUM_CH +: NUM_CH]),
            .ptr   (ptr_eff[l]),
            .found (lvl_hit[l]),
            .idx   (lvl_idx[l])
        );
        assign lvl_any_nxt[l] = |(pend & lvl_en_i[l*NUM_CH +: NUM_CH]);
    end

    always_comb begin
        any_cand = 1'b0;
        win_id   = '0;
        win_lvl  = '0;
        for (int l = NUM_LVL - 1; l >= 0; l--) begin
            if (lvl_hit[l]) begin
                any_cand = 1'b1;
                win_id   = lvl_idx[l];
                win_lvl  = LVL_W'(l);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            STATE_IDLE: if (any_cand) state_nxt = STATE_HOLD;
            STATE_HOLD: if (grant_ready_i && !any_cand) state_nxt = STATE_IDLE;
            default:    state_nxt = STATE_IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        unique case (state)
            STATE_IDLE: load = any_cand;
            STATE_HOLD: load = grant_ready_i && any_cand;
            default:    load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id_o  <= '0;
            grant_lvl_o <= '0;
            lvl_any_o   <= '0;
            pend        <= '0;
            req_q       <= '0;
        end else begin
            if (load) begin
                grant_id_o  <= win_id;
                grant_lvl_o <= win_lvl;
            end
            lvl_any_o <= lvl_any_nxt;
            pend      <= pend_next;
            req_q     <= req_i;
        end
    end

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// tb_irq_priority_arbiter: directed scenarios plus random traffic checked
// against a score-based reference model (IRQ_ARB_ROUND_ROBIN_EN aware).
module tb_irq_priority_arbiter;

    localparam int N  = 9;
    localparam int L  = 3;
    localparam int IW = 4;
    localparam int LW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_i;
    logic [N*L-1:0] lvl_en_i;
    logic           grant_valid_o;
    logic           grant_ready_i;
    logic [IW-1:0]  grant_id_o;
    logic [LW-1:0]  grant_lvl_o;
    logic [L-1:0]   lvl_any_o;
    logic [N-1:0]   pend_o;

    int n_tests = 0;
    int n_fail  = 0;

    bit [N-1:0] m_pend;
    bit [N-1:0] m_reqq;
    bit [L-1:0] m_any;
    bit         m_valid;
    int         m_id;
    int         m_lvl;
    int         m_ptr [L];

    irq_priority_arbiter u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .lvl_en_i      (lvl_en_i),
        .grant_valid_o (grant_valid_o),
        .grant_ready_i (grant_ready_i),
        .grant_id_o    (grant_id_o),
        .grant_lvl_o   (grant_lvl_o),
        .lvl_any_o     (lvl_any_o),
        .pend_o        (pend_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_reqq  = '0;
        m_any   = '0;
        m_valid = 1'b0;
        m_id    = 0;
        m_lvl   = 0;
        for (int l = 0; l < L; l++) m_ptr[l] = 0;
    endtask

    // Winner = lowest level, then smallest distance from that level's pointer.
    task automatic model_step(input bit [N-1:0] r, input bit [N*L-1:0] e,
                              input bit rdy);
        bit         hs;
        bit         found;
        bit [N-1:0] np;
        bit [N-1:0] s;
        int         best;
        int         bestd;
        int         d;
        hs = m_valid && rdy;
        for (int l = 0; l < L; l++) begin
            m_any[l] = 1'b0;
            for (int c = 0; c < N; c++)
                if (m_pend[c] && e[l*N+c]) m_any[l] = 1'b1;
        end
        np = m_pend;
        if (hs) np[m_id] = 1'b0;
        np = np | (r & ~m_reqq);
`ifdef IRQ_ARB_ROUND_ROBIN_EN
        if (hs) m_ptr[m_lvl] = (m_id + 1) % N;
`endif
        if (!m_valid || hs) begin
            s = hs ? np : m_pend;
            found = 1'b0;
            for (int l = 0; l < L && !found; l++) begin
                best  = -1;
                bestd = N;
                for (int c = 0; c < N; c++) begin
                    if (s[c] && e[l*N+c]) begin
                        d = (c - m_ptr[l] + N) % N;
                        if (d < bestd) begin
                            bestd = d;
                            best  = c;
                        end
                    end
                end
                if (best >= 0) begin
                    found = 1'b1;
                    m_id  = best;
                    m_lvl = l;
                end
            end
            m_valid = found;
        end
        m_pend = np;
        m_reqq = r;
    endtask

    task automatic compare_all();
        chk("valid", grant_valid_o, m_valid);
        chk("id", grant_id_o, m_id);
        chk("lvl", grant_lvl_o, m_lvl);
        chk("pend", pend_o, m_pend);
        chk("lvl_any", lvl_any_o, m_any);
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N*L-1:0] e,
                         input logic rdy);
        req_i         = r;
        lvl_en_i      = e;
        grant_ready_i = rdy;
        @(posedge clk);
        model_step(r, e, rdy);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [N*L-1:0] enb(input int l, input int c);
        logic [N*L-1:0] v;
        v = '0;
        v[l*N+c] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [N*L-1:0] e;
        logic [N-1:0]   r;
        int             rr_got [$];
        int             rr_exp [6];

        rst = 1'b1;
        req_i = '0;
        lvl_en_i = '0;
        grant_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", grant_valid_o, 0);
        chk("rst_id", grant_id_o, 0);
        chk("rst_lvl", grant_lvl_o, 0);
        chk("rst_any", lvl_any_o, 0);
        chk("rst_pend", pend_o, 0);
        rst = 1'b0;

        // Single request at level 1, held until ready
        e = enb(1, 5);
        cycle(9'h020, e, 1'b0);
        chk("t1_pend", pend_o[5], 1);
        chk("t1_nvalid", grant_valid_o, 0);
        cycle(9'h020, e, 1'b0);
        chk("t1_valid", grant_valid_o, 1);
        chk("t1_id", grant_id_o, 5);
        chk("t1_lvl", grant_lvl_o, 1);
        chk("t1_any", lvl_any_o, 3'b010);
        repeat (3) cycle(9'h020, e, 1'b0);
        chk("t1_hold_id", grant_id_o, 5);
        chk("t1_hold_v", grant_valid_o, 1);
        cycle(9'h020, e, 1'b1);
        chk("t1_done", grant_valid_o, 0);
        cycle(9'h000, e, 1'b0);

        // Two levels resolved back to back
        e = enb(2, 2) | enb(0, 7);
        cycle(9'h084, e, 1'b1);
        cycle(9'h084, e, 1'b1);
        chk("t2_id0", grant_id_o, 7);
        chk("t2_lvl0", grant_lvl_o, 0);
        chk("t2_any", lvl_any_o, 3'b101);
        cycle(9'h084, e, 1'b1);
        chk("t2_id1", grant_id_o, 2);
        chk("t2_lvl1", grant_lvl_o, 2);
        cycle(9'h084, e, 1'b1);
        chk("t2_idle", grant_valid_o, 0);
        cycle(9'h000, e, 1'b0);

        // No preemption by a higher-priority arrival
        e = enb(1, 3) | enb(0, 0);
        cycle(9'h008, e, 1'b0);
        cycle(9'h008, e, 1'b0);
        cycle(9'h009, e, 1'b0);
        cycle(9'h009, e, 1'b0);
        chk("t3_hold_id", grant_id_o, 3);
        chk("t3_hold_lvl", grant_lvl_o, 1);
        cycle(9'h009, e, 1'b1);
        chk("t3_next_id", grant_id_o, 0);
        chk("t3_next_lvl", grant_lvl_o, 0);
        chk("t3_next_v", grant_valid_o, 1);
        cycle(9'h009, e, 1'b1);
        cycle(9'h000, e, 1'b0);

        // Set beats clear on the same channel
        e = enb(0, 4);
        cycle(9'h010, e, 1'b0);
        cycle(9'h010, e, 1'b0);
        cycle(9'h000, e, 1'b0);
        cycle(9'h010, e, 1'b1);
        chk("t4_pend", pend_o[4], 1);
        chk("t4_valid", grant_valid_o, 1);
        chk("t4_id", grant_id_o, 4);
        cycle(9'h010, e, 1'b1);
        chk("t4_clear", pend_o[4], 0);
        chk("t4_idle", grant_valid_o, 0);
        cycle(9'h000, e, 1'b0);

        // Re-pended channels at one level
        e = enb(0, 1) | enb(0, 2) | enb(0, 6);
`ifdef IRQ_ARB_ROUND_ROBIN_EN
        rr_exp = '{1, 2, 6, 1, 2, 6};
`else
        rr_exp = '{1, 2, 1, 2, 1, 2};
`endif
        for (int k = 0; k < 7; k++) begin
            r = 9'h046;
            if (m_valid) r[m_id] = 1'b0;
            cycle(r, e, 1'b1);
            if (grant_valid_o) rr_got.push_back(int'(grant_id_o));
        end
        chk("rr_count", rr_got.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < rr_got.size()) chk("rr_order", rr_got[k], rr_exp[k]);
        end
        repeat (4) cycle(9'h000, e, 1'b1);

        // Asynchronous reset while a grant is held
        e = enb(0, 3);
        cycle(9'h008, e, 1'b0);
        cycle(9'h008, e, 1'b0);
        chk("t6_pre_v", grant_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_v", grant_valid_o, 0);
        chk("t6_rst_id", grant_id_o, 0);
        chk("t6_rst_pend", pend_o, 0);
        chk("t6_rst_any", lvl_any_o, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(9'h008, e, 1'b0);
        chk("t6_rel_pend", pend_o[3], 1);
        chk("t6_rel_nv", grant_valid_o, 0);
        cycle(9'h008, e, 1'b0);
        chk("t6_rel_v", grant_valid_o, 1);
        chk("t6_rel_id", grant_id_o, 3);
        cycle(9'h008, e, 1'b1);
        cycle(9'h000, e, 1'b0);

        // Random traffic
        e = '0;
        for (int k = 0; k < 400; k++) begin
            if (k % 16 == 0) begin
                for (int l = 0; l < L; l++)
                    e[l*N +: N] = N'($urandom & $urandom);
            end
            r = N'($urandom & $urandom);
            cycle(r, e, 1'(($urandom_range(0, 3) != 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
